rtc_reg_bank: RTL

RTC_REG_BANK -- requirements
Module: rtc_reg_bank

---
 rtl/rtc_reg_bank.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/rtc_reg_bank.sv
// rtc_reg_bank -- register bank behind an RTC read sequencer.
//
// Drives the register address onto the multiplexed AD bus during the
// sequencer's address phase, captures the byte returned in each data phase
// into a per-register shadow slot, and commits all nine shadows to the
// outputs atomically once a complete frame has been seen. A frame holding
// any non-BCD byte is dropped and reported instead of committed.
//
// Ports:
//   clk, reset                   clock; synchronous active-low reset
//   reg_to_rtc, rtc_to_reg       sequencer address / data phase flags
//   dir_sel[9:0]                 one-hot address select (bit0 = com_cyt)
//   dat_sel[8:0]                 one-hot data select (seg .. hora_tim)
//   ad_in[7:0]                   resolved AD bus value
//   ad_out[7:0], ad_oe           registered address byte and drive enable
//   seg .. hora_tim [7:0]        committed BCD values
//   frame_valid, frame_err       one-cycle commit / discard pulses

// One shadow slot: holds the last byte captured for a register in the
// current frame, plus whether it has been seen and whether it was bad BCD.
// A capture wins over a same-cycle clear so it starts the next frame.
module rtc_reg_slot (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       take,
    input  logic [7:0] din,
    output logic [7:0] shadow,
    output logic       seen,
    output logic       bad
);
    always_ff @(posedge clk) begin
        if (!reset) begin
            shadow <= '0;
            seen   <= 1'b0;
            bad    <= 1'b0;
        end else if (take) begin
            shadow <= din;
            seen   <= 1'b1;
            bad    <= (din[7:4] > 4'd9) || (din[3:0] > 4'd9);
        end else if (clr) begin
            seen   <= 1'b0;
            bad    <= 1'b0;
        end
    end
endmodule

module rtc_reg_bank (
    input  logic       clk,
    input  logic       reset,
    input  logic       reg_to_rtc,
    input  logic       rtc_to_reg,
    input  logic [9:0] dir_sel,
    input  logic [8:0] dat_sel,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic [7:0] seg,
    output logic [7:0] min,
    output logic [7:0] hora,
    output logic [7:0] dia,
    output logic [7:0] mes,
    output logic [7:0] anio,
    output logic [7:0] seg_tim,
    output logic [7:0] min_tim,
    output logic [7:0] hora_tim,
    output logic       frame_valid,
    output logic       frame_err
);
    localparam int NUM_REGS = 9;

    // Index 0 is com_cyt, 1..9 follow the output order.
    localparam logic [9:0][7:0] ADDR_MAP = {
        8'h43, 8'h42, 8'h41, 8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21, 8'hF0
    };

    typedef enum logic [1:0] {IDLE, COLLECT, COMMIT} state_t;

    state_t                          state;
    logic   [7:0]                    ad_q;
    logic   [NUM_REGS-1:0]           cap, cap_q, take;
    logic   [NUM_REGS-1:0]           seen, bad;
    logic   [NUM_REGS-1:0][7:0]      shadow, cmt;
    logic                            drive;
    logic   [7:0]                    addr_nxt;
    logic                            sof, sof_q, sof_rise, clr;

    // Address phase: only a clean, unambiguous select drives the bus.
    always_comb begin
        drive    = reg_to_rtc & ~rtc_to_reg & $onehot(dir_sel);
        addr_nxt = '0;
        for (int i = 0; i < 10; i++)
            if (drive && dir_sel[i]) addr_nxt = addr_nxt | ADDR_MAP[i];
    end

    // Data is taken on the trailing edge of the capture strobe, so ad_q holds
    // the bus value from the last cycle of the data phase.
    assign cap  = {NUM_REGS{rtc_to_reg & ~reg_to_rtc & $onehot(dat_sel)}} & dat_sel;
    assign take = cap_q & ~cap;

    assign sof      = reg_to_rtc & dir_sel[0];
    assign sof_rise = sof & ~sof_q;

    // Shadows are cleared after a commit attempt, or when a new frame starts
    // before the current one completed.
    assign clr = (state == COMMIT) || ((state == COLLECT) && sof_rise);

    genvar g;
    for (g = 0; g < NUM_REGS; g++) begin : g_slot
        rtc_reg_slot u_slot (
            .clk    (clk),
            .reset  (reset),
            .clr    (clr),
            .take   (take[g]),
            .din    (ad_q),
            .shadow (shadow[g]),
            .seen   (seen[g]),
            .bad    (bad[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            ad_q        <= '0;
            cap_q       <= '0;
            sof_q       <= 1'b0;
            ad_out      <= '0;
            ad_oe       <= 1'b0;
            cmt         <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            ad_q        <= ad_in;
            cap_q       <= cap;
            sof_q       <= sof;
            ad_out      <= addr_nxt;
            ad_oe       <= drive;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (|take) state <= COLLECT;
                end
                COLLECT: begin
                    if (sof_rise)  state <= IDLE;
                    else if (&seen) state <= COMMIT;
                end
                COMMIT: begin
                    state <= IDLE;
                    if (bad == '0) begin
                        cmt         <= shadow;
                        frame_valid <= 1'b1;
                    end else begin
                        frame_err   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign seg      = cmt[0];
    assign min      = cmt[1];
    assign hora     = cmt[2];
    assign dia      = cmt[3];
    assign mes      = cmt[4];
    assign anio     = cmt[5];
    assign seg_tim  = cmt[6];
    assign min_tim  = cmt[7];
    assign hora_tim = cmt[8];
endmodule
